// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences the shared ALU, memory port and extender.
// State advances one step per cycle; FETCH, MEMREAD and MEMWRITE stall until i_memReady.
module multicycle_controller (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instruction,
    input  logic        i_zero,
    input  logic        i_memReady,
    output logic        o_pcWrite,
    output logic        o_adrSrc,
    output logic        o_memWrite,
    output logic        o_irWrite,
    output logic        o_regWrite,
    output logic [1:0]  o_resultSrc,
    output logic [1:0]  o_aluSrcA,
    output logic [1:0]  o_aluSrcB,
    output logic [1:0]  o_aluOp,
    output logic [1:0]  o_immSrc,
    output logic        o_illegal,
    output logic [3:0]  o_state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t      state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        pc_we, mem_we, ir_we, reg_we;
    logic        unused_bits;

    assign opcode      = i_instruction[6:0];
    assign funct3      = i_instruction[14:12];
    assign unused_bits = ^{i_instruction[31:15], i_instruction[11:7]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (i_memReady) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)       state_d = S_MEMADR;
                else if (opcode == OP_R)                      state_d = S_EXECUTER;
                else if (opcode == OP_I)                      state_d = S_EXECUTEI;
                else if (opcode == OP_BR && funct3 == 3'b000) state_d = S_BEQ;
                else if (opcode == OP_JAL)                    state_d = S_JAL;
                else                                          state_d = S_TRAP;
            end
            // Opcode cannot change after DECODE, so anything but lw/sw here is corruption.
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMREAD;
                else if (opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_TRAP;
            end
            S_MEMREAD:  if (i_memReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (i_memReady) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        pc_we       = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        o_adrSrc    = 1'b0;
        o_resultSrc = 2'b00;
        o_aluSrcA   = 2'b00;
        o_aluSrcB   = 2'b00;
        o_aluOp     = 2'b00;
        case (state_q)
            S_FETCH: begin
                o_aluSrcB   = 2'b10;
                o_resultSrc = 2'b10;
                ir_we       = i_memReady;
                pc_we       = i_memReady;
            end
            S_DECODE: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b01;
            end
            S_MEMADR: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
            end
            S_MEMREAD:  o_adrSrc = 1'b1;
            S_MEMWB: begin
                o_resultSrc = 2'b01;
                reg_we      = 1'b1;
            end
            S_MEMWRITE: begin
                o_adrSrc = 1'b1;
                mem_we   = 1'b1;
            end
            S_EXECUTER: begin
                o_aluSrcA = 2'b10;
                o_aluOp   = 2'b10;
            end
            S_EXECUTEI: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
                o_aluOp   = 2'b10;
            end
            S_ALUWB:    reg_we = 1'b1;
            S_BEQ: begin
                o_aluSrcA = 2'b10;
                o_aluOp   = 2'b01;
                pc_we     = i_zero;
            end
            S_JAL: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b10;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   o_immSrc = 2'b01;
            OP_BR:   o_immSrc = 2'b10;
            OP_JAL:  o_immSrc = 2'b11;
            default: o_immSrc = 2'b00;
        endcase
    end

    // Reset gating keeps FETCH's ready-driven enables quiet while i_rst is held.
    assign o_pcWrite  = pc_we  & ~i_rst;
    assign o_memWrite = mem_we & ~i_rst;
    assign o_irWrite  = ir_we  & ~i_rst;
    assign o_regWrite = reg_we & ~i_rst;
    assign o_illegal  = (state_q == S_TRAP) & ~i_rst;
    assign o_state    = state_q;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RISC-V core.
- Sequences one shared ALU, one shared memory port and the immediate extender across fetch, decode, execute, memory and writeback steps.
- Decodes the opcode held in the instruction register and drives all datapath selects and write enables, including the immediate-format select.
- Waits on a memory-ready handshake; traps on unsupported opcodes.

Parameters:
None.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_instruction  input  32  instruction register contents (valid from DECODE onward)
i_zero  input  1  ALU zero flag
i_memReady  input  1  shared memory completes the current access this cycle
o_pcWrite  output  1  PC register write enable
o_adrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
o_memWrite  output  1  memory write request
o_irWrite  output  1  instruction register and OldPC write enable
o_regWrite  output  1  register file write enable
o_resultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
o_aluSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
o_aluSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
o_aluOp  output  2  ALU operation: 00 = add, 01 = subtract, 10 = decode from funct3/funct7
o_immSrc  output  2  extender format: 00 = I, 01 = S, 10 = B, 11 = J
o_illegal  output  1  sticky flag: unsupported instruction trapped
o_state  output  4  current state encoding, for debug

Behaviour:
- State register resets asynchronously to FETCH. While i_rst is high, every enable (pcWrite, memWrite, irWrite, regWrite) and o_illegal is 0.
- Unless a state lists it otherwise, every output is 0.
- o_immSrc is combinational from i_instruction[6:0]:
  - 0000011 / 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - anything else -> 00
- State encodings and behaviour:
  - FETCH (0): adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10. irWrite=pcWrite=i_memReady. Holds in FETCH until i_memReady, then goes to DECODE.
  - DECODE (1): aluSrcA=01, aluSrcB=01, aluOp=00 (branch target into ALUOut). Next state by opcode:
    - lw or sw -> MEMADR
    - R-type 0110011 -> EXECUTER
    - I-ALU 0010011 -> EXECUTEI
    - beq (1100011 with funct3=000) -> BEQ
    - jal -> JAL
    - anything else -> TRAP
  - MEMADR (2): aluSrcA=10, aluSrcB=01, aluOp=00. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD (3): adrSrc=1, resultSrc=00. Holds until i_memReady, then goes to MEMWB.
  - MEMWB (4): resultSrc=01, regWrite=1. Goes to FETCH.
  - MEMWRITE (5): adrSrc=1, memWrite=1. memWrite is held high until i_memReady, then goes to FETCH.
  - EXECUTER (6): aluSrcA=10, aluSrcB=00, aluOp=10. Goes to ALUWB.
  - EXECUTEI (7): aluSrcA=10, aluSrcB=01, aluOp=10. Goes to ALUWB.
  - ALUWB (8): resultSrc=00, regWrite=1. Goes to FETCH.
  - BEQ (9): aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, pcWrite=i_zero. Goes to FETCH.
  - JAL (10): aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcWrite=1. Goes to ALUWB, which writes PC+4 to rd.
  - TRAP (11): o_illegal=1, all enables 0. Stays in TRAP until reset.
  - Encodings 12–15: unreachable; go to TRAP.
- Cycles per instruction with i_memReady tied high: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4. Each wait cycle adds 1.
- i_memReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- o_immSrc in DECODE and later states reflects the latched instruction. In FETCH its value is don't-care to the datapath.
- Reset asserted mid-instruction: state returns to FETCH immediately. No write enable fires afterward.

Test Plan:
- Reset, then 0x00802283 (lw x5,8(x0)) with ready=1 -> state sequence 0,1,2,3,4,0; regWrite high only in state 4; immSrc=00.
- 0x00502223 (sw) with i_memReady low 3 cycles in MEMWRITE -> memWrite high for 4 cycles; immSrc=01; back to FETCH; regWrite never asserted.
- 0x003100B3 (add) then 0x00000463 (beq) with i_zero=1 -> add: aluOp=10 in EXECUTER, then ALUWB. beq: BEQ state with aluOp=01, immSrc=10, pcWrite=1. Repeat beq with i_zero=0 -> pcWrite=0.
- 0x008000EF (jal) -> states 0,1,10,8,0; pcWrite=1 in JAL; immSrc=11; regWrite in ALUWB.
- Illegal 0x0000007F, and beq opcode with funct3=001 -> TRAP, o_illegal=1 and stays 1, no enables. i_rst pulse -> FETCH, o_illegal=0.
- Assert i_rst asynchronously mid-MEMREAD -> state 0 without a clock edge; no regWrite; normal fetch resumes after release.
